// File: rtl/rs_latch_pkg.sv
// Shared definitions for the RS latch bank: conflict-resolution mode codes and
// the per-channel next-state function used by every latch cell.
package rs_latch_pkg;

    localparam logic [1:0] MODE_HOLD    = 2'd0;
    localparam logic [1:0] MODE_RST_DOM = 2'd1;
    localparam logic [1:0] MODE_SET_DOM = 2'd2;
    localparam logic [1:0] MODE_TOGGLE  = 2'd3;

    // s=r=1 is resolved by the mode instead of producing the classic forbidden state.
    function automatic logic next_q(
        input logic       q,
        input logic       s,
        input logic       r,
        input logic       en,
        input logic [1:0] mode
    );
        logic nxt;
        nxt = q;
        if (en) begin
            case ({s, r})
                2'b10:   nxt = 1'b1;
                2'b01:   nxt = 1'b0;
                2'b11: begin
                    case (mode)
                        MODE_HOLD:    nxt = q;
                        MODE_RST_DOM: nxt = 1'b0;
                        MODE_SET_DOM: nxt = 1'b1;
                        default:      nxt = ~q;
                    endcase
                end
                default: nxt = q;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rs_latch_cell.sv
// Single-channel registered RS latch with complement output and a conflict
// indicator (s, r and en all high) for the bank's status logic.
module rs_latch_cell
    import rs_latch_pkg::*;
#(
    parameter logic [1:0] MODE = MODE_RST_DOM,
    parameter logic       INIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    input  logic en,
    output logic q,
    output logic nq,
    output logic hit
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = next_q(q_q, s, r, en, MODE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= INIT;
        end else begin
            q_q <= q_d;
        end
    end

    // nq is a pure inverter of the state flop, so it can never disagree with q.
    assign q   = q_q;
    assign nq  = ~q_q;
    assign hit = en & s & r;

endmodule

// File: rtl/rs_latch_bank.sv
// Bank of CH clocked RS latches with mode-based conflict resolution, sticky
// conflict flags and a saturating conflict counter. Optional input
// synchronisers are built when RS_LATCH_BANK_SYNC_EN is defined.
module rs_latch_bank
    import rs_latch_pkg::*;
#(
    parameter int            CH    = 4,
    parameter int            MODE  = 1,
    parameter int            CNT_W = 8,
    parameter logic [CH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH-1:0]    r,
    input  logic [CH-1:0]    s,
    input  logic [CH-1:0]    en,
    input  logic             clr_conf,
    output logic [CH-1:0]    q,
    output logic [CH-1:0]    nq,
    output logic [CH-1:0]    conf_flag,
    output logic [CNT_W-1:0] conf_cnt,
    output logic             any_conf
);

    localparam logic [1:0]       MODE_SEL = 2'(MODE);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CH-1:0] sEff;
    logic [CH-1:0] rEff;
    logic [CH-1:0] enEff;
    logic [CH-1:0] hit;

`ifdef RS_LATCH_BANK_SYNC_EN
    logic [CH-1:0] sMeta_q;
    logic [CH-1:0] sSync_q;
    logic [CH-1:0] rMeta_q;
    logic [CH-1:0] rSync_q;
    logic [CH-1:0] enMeta_q;
    logic [CH-1:0] enSync_q;

    // Two-flop synchronisers for requests arriving from other clock domains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sMeta_q  <= '0;
            sSync_q  <= '0;
            rMeta_q  <= '0;
            rSync_q  <= '0;
            enMeta_q <= '0;
            enSync_q <= '0;
        end else begin
            sMeta_q  <= s;
            sSync_q  <= sMeta_q;
            rMeta_q  <= r;
            rSync_q  <= rMeta_q;
            enMeta_q <= en;
            enSync_q <= enMeta_q;
        end
    end

    assign sEff  = sSync_q;
    assign rEff  = rSync_q;
    assign enEff = enSync_q;
`else
    assign sEff  = s;
    assign rEff  = r;
    assign enEff = en;
`endif

    for (genvar g = 0; g < CH; g++) begin : gCell
        rs_latch_cell #(
            .MODE (MODE_SEL),
            .INIT (INIT[g])
        ) uCell (
            .clk (clk),
            .rst (rst),
            .s   (sEff[g]),
            .r   (rEff[g]),
            .en  (enEff[g]),
            .q   (q[g]),
            .nq  (nq[g]),
            .hit (hit[g])
        );
    end

    logic [CH-1:0]    confFlag_q;
    logic [CH-1:0]    confFlag_d;
    logic [CNT_W-1:0] confCnt_q;
    logic [CNT_W-1:0] confCnt_d;

    // A clear wins over any conflict seen on the same edge.
    always_comb begin
        confFlag_d = confFlag_q | hit;
        confCnt_d  = confCnt_q;
        if ((|hit) && (confCnt_q != CNT_MAX)) begin
            confCnt_d = confCnt_q + 1'b1;
        end
        if (clr_conf) begin
            confFlag_d = '0;
            confCnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            confFlag_q <= '0;
            confCnt_q  <= '0;
        end else begin
            confFlag_q <= confFlag_d;
            confCnt_q  <= confCnt_d;
        end
    end

    assign conf_flag = confFlag_q;
    assign conf_cnt  = confCnt_q;
    assign any_conf  = |confFlag_q;

endmodule
